// File: rtl/mm_pkg.sv
// mm_out_sched shared types and constants.
// Descriptor layout, FSM states and settle margin.
package mm_pkg;

    localparam int F_LEN_W   = 10;
    localparam int FWB_W     = 5;
    localparam int WWB_W     = 5;
    localparam int SHIFT_W   = 20;
    localparam int OUT_DEPTH = 2400;

    localparam int SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PASS,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [F_LEN_W-1:0] F_length;
        logic [FWB_W-1:0]   F_width_block_num;
        logic [WWB_W-1:0]   W_width_block_num;
        logic [SHIFT_W-1:0] shift;
    } desc_t;

endpackage

// File: rtl/mm_out_sched_if.sv
// Descriptor, pass and drain signals between the layer
// controller/feeder/buffer side and the job sequencer.
interface mm_out_sched_if
    import mm_pkg::*;
#(
    parameter int F_length_width          = F_LEN_W,
    parameter int F_width_block_num_width = FWB_W,
    parameter int W_width_block_num_width = WWB_W,
    parameter int shift_width             = SHIFT_W
) ();

    logic                               cfg_valid;
    logic                               cfg_ready;
    logic [F_length_width-1:0]          cfg_F_length;
    logic [F_width_block_num_width-1:0] cfg_F_width_block_num;
    logic [W_width_block_num_width-1:0] cfg_W_width_block_num;
    logic [shift_width-1:0]             cfg_shift;

    logic [F_length_width-1:0]          buf_F_length;
    logic [F_width_block_num_width-1:0] buf_F_width_block_num;
    logic [W_width_block_num_width-1:0] buf_W_width_block_num;
    logic [shift_width-1:0]             buf_shift;

    logic                               pass_start;
    logic                               pass_last;
    logic                               drain_last;
    logic [F_width_block_num_width-1:0] pass_idx;
    logic                               busy;
    logic                               job_done;
    logic                               err;
    logic                               err_clr;

    modport master (
        output cfg_valid, cfg_F_length, cfg_F_width_block_num,
        output cfg_W_width_block_num, cfg_shift,
        output pass_last, drain_last, err_clr,
        input  cfg_ready, buf_F_length, buf_F_width_block_num,
        input  buf_W_width_block_num, buf_shift,
        input  pass_start, pass_idx, busy, job_done, err
    );

    modport slave (
        input  cfg_valid, cfg_F_length, cfg_F_width_block_num,
        input  cfg_W_width_block_num, cfg_shift,
        input  pass_last, drain_last, err_clr,
        output cfg_ready, buf_F_length, buf_F_width_block_num,
        output buf_W_width_block_num, buf_shift,
        output pass_start, pass_idx, busy, job_done, err
    );

endinterface

// File: rtl/mm_cfg_check.sv
// Descriptor sanity check: rejects zero fields and jobs
// whose row x column-block footprint exceeds the buffer.
module mm_cfg_check
    import mm_pkg::*;
#(
    parameter int F_length_width          = F_LEN_W,
    parameter int W_width_block_num_width = WWB_W,
    parameter int OUT_Feature_Block_num   = OUT_DEPTH
) (
    input  desc_t desc,
    output logic  cfg_bad
);

    localparam int PW = F_length_width + W_width_block_num_width;
    localparam logic [PW-1:0] CAP = PW'(OUT_Feature_Block_num);

    logic [PW-1:0] prod;
    logic          zero_f;

    // Full-width product so the capacity compare never wraps
    always_comb begin
        prod   = PW'(desc.F_length) * PW'(desc.W_width_block_num);
        zero_f = (desc.F_length == '0)
               | (desc.F_width_block_num == '0)
               | (desc.W_width_block_num == '0)
               | (desc.shift == '0);
        cfg_bad = zero_f | (prod > CAP);
    end

endmodule

// File: rtl/mm_out_sched.sv
// Output-buffer job sequencer: latches one descriptor,
// issues one start per accumulation pass, waits for drain.
module mm_out_sched
    import mm_pkg::*;
#(
    parameter int F_length_width          = F_LEN_W,
    parameter int F_width_block_num_width = FWB_W,
    parameter int W_width_block_num_width = WWB_W,
    parameter int shift_width             = SHIFT_W,
    parameter int OUT_Feature_Block_num   = OUT_DEPTH
) (
    input logic           clk,
    input logic           rst_n,
    mm_out_sched_if.slave bus
);

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE_CYCLES - 1);
    localparam logic [F_width_block_num_width-1:0] IDX_ONE = 1;

    logic [F_length_width-1:0]          in_len;
    logic [F_width_block_num_width-1:0] in_fwb;
    logic [W_width_block_num_width-1:0] in_wwb;
    logic [shift_width-1:0]             in_shift;

    desc_t  cfg_in;
    logic   cfg_bad;

    state_t state, state_n;
    desc_t  buf_q, buf_n;
    logic [F_width_block_num_width-1:0] pass_idx, idx_n;
    logic [1:0] settle_cnt, cnt_n;

    logic   cfg_ready_q;
    logic   busy_q;
    logic   pass_start_q;
    logic   job_done_q;
    logic   err_q, err_n, err_set;
    logic   accept;

    assign in_len   = bus.cfg_F_length;
    assign in_fwb   = bus.cfg_F_width_block_num;
    assign in_wwb   = bus.cfg_W_width_block_num;
    assign in_shift = bus.cfg_shift;

    assign cfg_in.F_length          = in_len;
    assign cfg_in.F_width_block_num = in_fwb;
    assign cfg_in.W_width_block_num = in_wwb;
    assign cfg_in.shift             = in_shift;

    mm_cfg_check #(
        .F_length_width          (F_length_width),
        .W_width_block_num_width (W_width_block_num_width),
        .OUT_Feature_Block_num   (OUT_Feature_Block_num)
    ) u_check (
        .desc    (cfg_in),
        .cfg_bad (cfg_bad)
    );

    // Next-state, next-config and error decisions
    always_comb begin
        state_n = state;
        buf_n   = buf_q;
        idx_n   = pass_idx;
        cnt_n   = settle_cnt;
        err_set = 1'b0;
        accept  = (state == S_IDLE) & bus.cfg_valid & cfg_ready_q;

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cfg_bad) begin
                        err_set = 1'b1;
                    end else begin
                        buf_n   = cfg_in;
                        idx_n   = '0;
                        cnt_n   = '0;
                        state_n = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_n = S_PASS;
                end else begin
                    cnt_n = settle_cnt + 2'd1;
                end
            end
            S_PASS: begin
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (bus.pass_last) begin
                    if (pass_idx == buf_q.F_width_block_num - IDX_ONE) begin
                        state_n = S_DRAIN;
                    end else begin
                        idx_n   = pass_idx + IDX_ONE;
                        state_n = S_PASS;
                    end
                end
            end
            S_DRAIN: begin
                if (bus.drain_last) begin
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (bus.pass_last && (state != S_WAIT)) begin
            err_set = 1'b1;
        end
        if (bus.drain_last && (state != S_DRAIN)) begin
            err_set = 1'b1;
        end

        // A fresh error beats a simultaneous clear
        err_n = err_set | (err_q & ~bus.err_clr);
    end

    // State, config and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            buf_q        <= '0;
            pass_idx     <= '0;
            settle_cnt   <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            pass_start_q <= 1'b0;
            job_done_q   <= 1'b0;
            cfg_ready_q  <= 1'b1;
        end else begin
            state        <= state_n;
            buf_q        <= buf_n;
            pass_idx     <= idx_n;
            settle_cnt   <= cnt_n;
            err_q        <= err_n;
            busy_q       <= (state_n != S_IDLE);
            pass_start_q <= (state_n == S_PASS);
            job_done_q   <= (state_n == S_DONE);
            cfg_ready_q  <= (state_n == S_IDLE) & ~err_n;
        end
    end

    assign bus.cfg_ready             = cfg_ready_q;
    assign bus.buf_F_length          = buf_q.F_length;
    assign bus.buf_F_width_block_num = buf_q.F_width_block_num;
    assign bus.buf_W_width_block_num = buf_q.W_width_block_num;
    assign bus.buf_shift             = buf_q.shift;
    assign bus.pass_start            = pass_start_q;
    assign bus.pass_idx              = pass_idx;
    assign bus.busy                  = busy_q;
    assign bus.job_done              = job_done_q;
    assign bus.err                   = err_q;

endmodule

// File: tb/tb_mm_out_sched.sv
// Self-checking bench for mm_out_sched: directed scenarios
// plus randomized jobs against a transaction-level model.
module tb_mm_out_sched;
    import mm_pkg::*;

    logic clk;
    logic rst_n;

    mm_out_sched_if bus ();

    mm_out_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks;
    int failures;
    int ps_cnt;
    int jd_cnt;
    bit err_exp;
    desc_t buf_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.pass_start) ps_cnt++;
        if (bus.job_done) jd_cnt++;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic desc_t buf_now();
        desc_t d;
        d.F_length          = bus.buf_F_length;
        d.F_width_block_num = bus.buf_F_width_block_num;
        d.W_width_block_num = bus.buf_W_width_block_num;
        d.shift             = bus.buf_shift;
        return d;
    endfunction

    function automatic bit is_bad(input desc_t d);
        int area;
        area = int'(d.F_length) * int'(d.W_width_block_num);
        if (d.F_length == 0 || d.F_width_block_num == 0) return 1'b1;
        if (d.W_width_block_num == 0 || d.shift == 0) return 1'b1;
        return area > OUT_DEPTH;
    endfunction

    function automatic desc_t mk(input int l, input int f,
                                 input int w, input int s);
        desc_t d;
        d.F_length          = F_LEN_W'(l);
        d.F_width_block_num = FWB_W'(f);
        d.W_width_block_num = WWB_W'(w);
        d.shift             = SHIFT_W'(s);
        return d;
    endfunction

    task automatic drive_cfg(input desc_t d);
        bus.cfg_F_length          = d.F_length;
        bus.cfg_F_width_block_num = d.F_width_block_num;
        bus.cfg_W_width_block_num = d.W_width_block_num;
        bus.cfg_shift             = d.shift;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 64'(bus.busy), 64'(0));
        check({tag, "_rdy"}, 64'(bus.cfg_ready), 64'(1));
        check({tag, "_err"}, 64'(bus.err), 64'(0));
        check({tag, "_ps"}, 64'(bus.pass_start), 64'(0));
        check({tag, "_jd"}, 64'(bus.job_done), 64'(0));
        check({tag, "_idx"}, 64'(bus.pass_idx), 64'(0));
        check({tag, "_buf"}, 64'(buf_now()), 64'(0));
    endtask

    task automatic clear_err();
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        err_exp = 1'b0;
        check("err_clr", 64'(bus.err), 64'(0));
        check("clr_rdy", 64'(bus.cfg_ready), 64'(1));
    endtask

    task automatic accept(input desc_t d, input bit hold);
        int n;
        n = 0;
        drive_cfg(d);
        bus.cfg_valid = 1'b1;
        while (!bus.cfg_ready && n < 20) begin
            step();
            n++;
        end
        check("acc_timeout", 64'(bus.cfg_ready), 64'(1));
        step();
        bus.cfg_valid = hold;
    endtask

    task automatic run_body(input desc_t d, input int lat,
                            input int dlat, input bit spur,
                            input bit abort);
        int p0, j0, n, np;
        np = int'(d.F_width_block_num);
        p0 = ps_cnt;
        j0 = jd_cnt;
        for (int p = 0; p < np; p++) begin
            n = 0;
            while (!bus.pass_start && n < 20) begin
                step();
                n++;
            end
            check("ps_lat", 64'(n), 64'((p == 0) ? 2 : 0));
            check("pass_idx", 64'(bus.pass_idx), 64'(p));
            check("buf_pass", 64'(buf_now()), 64'(d));
            for (int i = 0; i < lat; i++) begin
                if (spur && p == 0 && i == 1) begin
                    bus.drain_last = 1'b1;
                    step();
                    bus.drain_last = 1'b0;
                    err_exp = 1'b1;
                    check("spur_err", 64'(bus.err), 64'(1));
                    check("spur_busy", 64'(bus.busy), 64'(1));
                    check("spur_ps", 64'(bus.pass_start), 64'(0));
                end else begin
                    step();
                end
            end
            bus.pass_last = 1'b1;
            step();
            bus.pass_last = 1'b0;
        end
        check("drain_ps", 64'(bus.pass_start), 64'(0));
        check("drain_busy", 64'(bus.busy), 64'(1));
        check("pass_cnt", 64'(ps_cnt - p0), 64'(np));
        if (abort) begin
            repeat (2) step();
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            err_exp = 1'b0;
            buf_exp = '0;
            check_reset_vals("rst_mid");
            bus.drain_last = 1'b1;
            step();
            bus.drain_last = 1'b0;
            err_exp = 1'b1;
            check("late_drain_err", 64'(bus.err), 64'(1));
            check("late_drain_busy", 64'(bus.busy), 64'(0));
            check("abort_jd", 64'(jd_cnt - j0), 64'(0));
            return;
        end
        repeat (dlat - 1) step();
        bus.drain_last = 1'b1;
        step();
        bus.drain_last = 1'b0;
        check("job_done", 64'(bus.job_done), 64'(1));
        check("done_busy", 64'(bus.busy), 64'(1));
        check("done_rdy", 64'(bus.cfg_ready), 64'(0));
        step();
        check("jd_pulse", 64'(bus.job_done), 64'(0));
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("idle_rdy", 64'(bus.cfg_ready), 64'(!err_exp));
        check("buf_hold", 64'(buf_now()), 64'(d));
        check("jd_cnt", 64'(jd_cnt - j0), 64'(1));
    endtask

    task automatic run_job(input desc_t d, input int lat,
                           input int dlat, input bit spur,
                           input bit abort);
        int p0;
        accept(d, 1'b0);
        if (is_bad(d)) begin
            err_exp = 1'b1;
            p0 = ps_cnt;
            check("bad_err", 64'(bus.err), 64'(1));
            check("bad_busy", 64'(bus.busy), 64'(0));
            check("bad_rdy", 64'(bus.cfg_ready), 64'(0));
            check("bad_buf", 64'(buf_now()), 64'(buf_exp));
            repeat (4) step();
            check("bad_rdy_hold", 64'(bus.cfg_ready), 64'(0));
            check("bad_nops", 64'(ps_cnt - p0), 64'(0));
            clear_err();
        end else begin
            check("acc_busy", 64'(bus.busy), 64'(1));
            check("acc_buf", 64'(buf_now()), 64'(d));
            check("acc_idx", 64'(bus.pass_idx), 64'(0));
            buf_exp = d;
            run_body(d, lat, dlat, spur, abort);
            if (err_exp) clear_err();
        end
    endtask

    desc_t d1, d2, rd;
    int mode, lat, dlat;
    bit spur;

    initial begin
        checks = 0;
        failures = 0;
        ps_cnt = 0;
        jd_cnt = 0;
        err_exp = 1'b0;
        buf_exp = '0;
        rst_n = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.pass_last = 1'b0;
        bus.drain_last = 1'b0;
        bus.err_clr = 1'b0;
        drive_cfg('0);
        step();
        step();
        check_reset_vals("reset");
        rst_n = 1'b1;
        step();

        d1 = mk(4, 2, 3, 8);
        run_job(d1, 10, 12, 1'b0, 1'b0);

        run_job(mk(100, 2, 30, 5), 1, 1, 1'b0, 1'b0);
        run_job(mk(81, 1, 30, 5), 1, 1, 1'b0, 1'b0);
        run_job(mk(0, 2, 3, 5), 1, 1, 1'b0, 1'b0);
        run_job(mk(80, 1, 30, 5), 3, 2, 1'b0, 1'b0);

        bus.pass_last = 1'b1;
        step();
        bus.pass_last = 1'b0;
        err_exp = 1'b1;
        check("idle_pl_err", 64'(bus.err), 64'(1));
        check("idle_pl_busy", 64'(bus.busy), 64'(0));
        bus.pass_last = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.pass_last = 1'b0;
        bus.err_clr = 1'b0;
        check("err_wins", 64'(bus.err), 64'(1));
        clear_err();

        run_job(mk(6, 3, 2, 1), 4, 3, 1'b1, 1'b0);

        d1 = mk(10, 2, 4, 7);
        d2 = mk(12, 1, 5, 9);
        accept(d1, 1'b1);
        drive_cfg(d2);
        check("b2b_busy1", 64'(bus.busy), 64'(1));
        run_body(d1, 3, 2, 1'b0, 1'b0);
        check("b2b_rdy", 64'(bus.cfg_ready), 64'(1));
        step();
        bus.cfg_valid = 1'b0;
        check("b2b_busy2", 64'(bus.busy), 64'(1));
        check("b2b_buf2", 64'(buf_now()), 64'(d2));
        check("b2b_idx", 64'(bus.pass_idx), 64'(0));
        run_body(d2, 2, 2, 1'b0, 1'b0);

        run_job(mk(7, 2, 2, 3), 2, 5, 1'b0, 1'b1);
        clear_err();

        run_job(mk(20, 1, 5, 3), 5, 4, 1'b0, 1'b0);

        for (int k = 0; k < 30; k++) begin
            mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                rd = mk($urandom_range(0, 1), $urandom_range(0, 1),
                        $urandom_range(0, 1), $urandom_range(0, 1));
            end else if (mode == 1) begin
                rd = mk($urandom_range(81, 1023), $urandom_range(1, 4),
                        $urandom_range(30, 31), $urandom_range(1, 99));
            end else begin
                rd = mk($urandom_range(1, 80), $urandom_range(1, 4),
                        $urandom_range(1, 30), $urandom_range(1, 999));
            end
            lat = int'($urandom_range(1, 6));
            dlat = int'($urandom_range(1, 6));
            spur = (lat >= 2) && ($urandom_range(0, 3) == 0);
            if (mode == 2 && $urandom_range(0, 1) == 1) begin
                bus.pass_last = 1'b1;
                step();
                bus.pass_last = 1'b0;
                err_exp = 1'b1;
                check("rnd_idle_pl", 64'(bus.err), 64'(1));
                clear_err();
            end
            run_job(rd, lat, dlat, spur, 1'b0);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mm_out_sched.md
# mm_out_sched

Job sequencer for the matrix-multiply output buffer (`MM_out_buffer`).
- Accepts one output-tile job descriptor at a time and holds the buffer's shape and shift configuration stable for the whole job.
- Issues one start pulse per accumulation pass to the systolic-array feeder and counts the pass-complete pulses.
- Waits for the buffer's drain to finish, then reports completion.
- Sits between the layer-level controller (descriptor source) and the feeder/buffer pair.

## Interface
Parameters:
- `F_length_width`, 10: width of the row-count field.
- `F_width_block_num_width`, 5: width of the accumulation-pass-count field.
- `W_width_block_num_width`, 5: width of the column-block-count field.
- `shift_width`, 20: width of the requant shift field.
- `OUT_Feature_Block_num`, 2400: buffer depth in entries; jobs larger than this are rejected.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1, `cfg_ready` out 1: descriptor handshake.
- `cfg_F_length` in `F_length_width`: rows in the job.
- `cfg_F_width_block_num` in `F_width_block_num_width`: accumulation passes in the job.
- `cfg_W_width_block_num` in `W_width_block_num_width`: column blocks in the job.
- `cfg_shift` in `shift_width`: requant shift.
- `buf_F_length`, `buf_F_width_block_num`, `buf_W_width_block_num`, `buf_shift` out (widths as above): registered configuration driven to the buffer.
- `pass_start` out 1: one-cycle pulse requesting one tile pass from the feeder.
- `pass_last` in 1: pass-complete pulse, same net as the buffer's `in_data_last`.
- `drain_last` in 1: buffer `out_data_last`, already ready-qualified.
- `pass_idx` out `F_width_block_num_width`: index of the current pass.
- `busy` out 1: high in every state except IDLE.
- `job_done` out 1: one-cycle completion pulse.
- `err` out 1: sticky error flag.
- `err_clr` in 1: clears `err`.

## Operation
States: IDLE, SETTLE, PASS, WAIT, DRAIN, DONE.
- **IDLE**
  - `cfg_ready = ~err`.
  - On `cfg_valid & cfg_ready` the descriptor is consumed.
  - If any field is zero, or `F_length*W_width_block_num > OUT_Feature_Block_num`, set `err` and stay in IDLE; `buf_*` are unchanged.
  - Otherwise register `buf_*` on that edge, clear `pass_idx`, and go to SETTLE.
- **SETTLE**: 2 cycles. The buffer registers its block size one cycle late, so this margin lets it settle. Then go to PASS.
- **PASS**: drive `pass_start` for 1 cycle, then go to WAIT.
- **WAIT**: on `pass_last`:
  - If `pass_idx == buf_F_width_block_num-1`, go to DRAIN.
  - Otherwise increment `pass_idx` and go to PASS.
- **DRAIN**: on `drain_last`, go to DONE.
- **DONE**: `job_done=1` for 1 cycle, then go to IDLE.

Error and boundary rules:
- `pass_last` outside WAIT, or `drain_last` outside DRAIN, sets `err`. The event is otherwise ignored and the state is unchanged.
- `err_clr` clears `err` on the next edge. If `err_clr` coincides with a new error, the error wins.
- `err` does not abort an active job. It only blocks the next descriptor.
- The product `F_length*W_width_block_num` is computed at full width (`F_length_width+W_width_block_num_width` bits), so it cannot overflow before the compare.
- `buf_*` never change while `busy=1`.

## Timing
- Reset values: state IDLE; all `buf_*` 0; `pass_idx` 0; `pass_start`, `job_done`, `busy` and `err` all 0. `cfg_ready` is 1 out of reset.
- Reset asserted mid-job: everything returns to these values on the next edge. An in-flight pass or drain is abandoned, and the buffer is flushed by its own reset.
- All outputs are registered.
- Descriptor accepted at edge T:
  - `busy` and `buf_*` are valid in cycle T+1.
  - `pass_start` is high in cycle T+3.
- `pass_last` sampled at edge E (not the final pass): the next `pass_start` is high in cycle E+1.
- Final `pass_last` sampled at edge E: DRAIN from cycle E+1.
- `drain_last` sampled at edge D: `job_done` is high in cycle D+1 and `cfg_ready` is high in cycle D+2.
- Minimum gap between jobs: one idle cycle.

## Structure
- Shared package `mm_pkg` holds:
  - the state enum;
  - the descriptor struct (`F_length`, `F_width_block_num`, `W_width_block_num`, `shift`);
  - `SETTLE_CYCLES = 2`.
- One sub-module, `mm_cfg_check`: the combinational zero-field and capacity check, which returns `cfg_bad`.
- Everything else is flat.

## Test plan
- **Single job.** Stimulus: `F_length=4`, `F_width_block_num=2`, `W_width_block_num=3`, `shift=8`; `pass_last` 10 cycles after each `pass_start`; `drain_last` 12 cycles after the final pass. Required: exactly 2 `pass_start` pulses, `pass_idx` stepping 0 then 1, one `job_done` pulse, `buf_*` = 4/2/3/8 throughout.
- **Oversize job.** Stimulus: `F_length=100`, `W_width_block_num=30` (3000 > 2400). Required: descriptor consumed, `err=1`, no `pass_start`, `cfg_ready=0` until `err_clr`, then back to 1.
- **Spurious events.** Stimulus: `pass_last` in IDLE; `drain_last` during WAIT. Required: `err` set in each case; state unchanged; the job still completes normally.
- **Back-to-back jobs.** Stimulus: `cfg_valid` held high with two descriptors. Required: the second is accepted exactly 2 cycles after the first job's `job_done`; `buf_*` switch only at that acceptance.
- **Reset mid-DRAIN.** Required: `rst_n=0` for 1 cycle returns all outputs to their reset values and gives `cfg_ready=1`; a later `drain_last` sets `err`.
- **Single-pass job.** Stimulus: `F_width_block_num=1`. Required: exactly one `pass_start`; DRAIN is entered on the first `pass_last`.
